soc_reset_sequencer: RTL and testbench



---
 rtl/soc_reset_pkg.sv | 24 ++
 rtl/reset_sync_debounce.sv | 72 +++++++
 rtl/soc_reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_soc_reset_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_reset_pkg.sv
// -----------------------------------------------------------------------------
// soc_reset_pkg
// Shared types and default constants for the SoC reset sequencer.
//   state_t          : sequencer states (HOLD, WAIT_LOCK, REL_PERIPH, RUN)
//   DEF_*            : default parameter values for soc_reset_sequencer
//   LOCK_LOSS_CNT_W  : width of the lock-loss event counter
// -----------------------------------------------------------------------------
package soc_reset_pkg;

  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    WAIT_LOCK  = 2'd1,
    REL_PERIPH = 2'd2,
    RUN        = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES           = 2;
  localparam int DEF_LOCK_STABLE_CYCLES    = 1024;
  localparam int DEF_PERIPH_TO_CORE_CYCLES = 16;
  localparam int DEF_DEBOUNCE_CYCLES       = 65536;

  localparam int LOCK_LOSS_CNT_W = 8;

endpackage

// File: rtl/reset_sync_debounce.sv
// -----------------------------------------------------------------------------
// reset_sync_debounce
// Multi-flop synchroniser for an asynchronous level, with an optional debounce
// stage behind it.
// Parameters:
//   STAGES          : flops in the synchroniser chain (min 2)
//   RESET_VAL       : value loaded into the chain and debounce register on reset
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles needed before the output
//                     follows the synchronised input; 0 bypasses the debouncer
// Ports:
//   i_clk    : clock
//   i_reset  : synchronous active-high reset
//   i_async  : asynchronous input level
//   o_value  : synchronised (and, if enabled, debounced) level
// -----------------------------------------------------------------------------
module reset_sync_debounce #(
  parameter int STAGES          = 2,
  parameter bit RESET_VAL       = 1'b0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_value
);

  logic [STAGES-1:0] r_sync;
  logic              w_sync;

  // NOTE: sequential state is updated with <= so every flop samples the values
  // from before the edge; blocking = here would collapse the chain into one flop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign w_sync = r_sync[STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign o_value = w_sync;
    end else begin : g_debounce
      localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);

      logic [DB_W-1:0] r_db_cnt;
      logic            r_db_val;

      // Count consecutive cycles where the synchronised input disagrees with
      // the debounced value; any agreeing cycle restarts the count.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_db_val <= RESET_VAL;
          r_db_cnt <= '0;
        end else if (w_sync == r_db_val) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_TC) begin
          r_db_val <= w_sync;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end

      assign o_value = r_db_val;
    end
  endgenerate

endmodule

// File: rtl/soc_reset_sequencer.sv
// -----------------------------------------------------------------------------
// soc_reset_sequencer
// Synchronises the CCC lock flag and the board reset button, waits for a
// stable lock, then releases peripheral reset followed by core reset.
// Any loss of lock or a debounced button press re-asserts both resets.
// Optional feature macro: RESET_SEQ_LOCK_LOSS_CNT_EN
//   defined   -> lock_loss_count counts lock drops seen in REL_PERIPH/RUN,
//                saturating at 255, cleared only by reset
//   undefined -> lock_loss_count is tied to 0
// Ports:
//   clk             : CCC fabric clock
//   reset           : synchronous active-high power-on reset
//   pll_lock        : CCC lock flag, asynchronous
//   ext_reset_n     : board button, active low, asynchronous, bouncing
//   periph_reset    : registered active-high reset to bus/peripherals
//   core_reset      : registered active-high reset to the CPU core
//   seq_done        : high while in RUN
//   lock_loss_count : lock-loss event count
// -----------------------------------------------------------------------------
module soc_reset_sequencer
  import soc_reset_pkg::*;
#(
  parameter int SYNC_STAGES           = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES    = DEF_LOCK_STABLE_CYCLES,
  parameter int PERIPH_TO_CORE_CYCLES = DEF_PERIPH_TO_CORE_CYCLES,
  parameter int DEBOUNCE_CYCLES       = DEF_DEBOUNCE_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pll_lock,
  input  logic                       ext_reset_n,
  output logic                       periph_reset,
  output logic                       core_reset,
  output logic                       seq_done,
  output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > PERIPH_TO_CORE_CYCLES) ?
                           LOCK_STABLE_CYCLES : PERIPH_TO_CORE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] P2C_TC  = CNT_W'(PERIPH_TO_CORE_CYCLES - 1);

  logic w_lock_s;
  logic w_btn_deb;
  logic w_fault;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_periph_reset, w_periph_reset_nxt;
  logic             r_core_reset, w_core_reset_nxt;
  logic             r_seq_done, w_seq_done_nxt;

  // NOTE: the button chain resets to 1 (released) so a power-on reset never
  // looks like a press once reset drops.
  reset_sync_debounce #(
    .STAGES          (SYNC_STAGES),
    .RESET_VAL       (1'b0),
    .DEBOUNCE_CYCLES (0)
  ) u_lock_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (pll_lock),
    .o_value (w_lock_s)
  );

  reset_sync_debounce #(
    .STAGES          (SYNC_STAGES),
    .RESET_VAL       (1'b1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (ext_reset_n),
    .o_value (w_btn_deb)
  );

  assign w_fault = !w_lock_s || !w_btn_deb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= HOLD;
      r_cnt          <= '0;
      r_periph_reset <= 1'b1;
      r_core_reset   <= 1'b1;
      r_seq_done     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_periph_reset <= w_periph_reset_nxt;
      r_core_reset   <= w_core_reset_nxt;
      r_seq_done     <= w_seq_done_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_periph_reset_nxt = r_periph_reset;
    w_core_reset_nxt   = r_core_reset;
    w_seq_done_nxt     = r_seq_done;

    unique case (r_state)
      HOLD: begin
        w_state_nxt        = WAIT_LOCK;
        w_cnt_nxt          = '0;
        w_periph_reset_nxt = 1'b1;
        w_core_reset_nxt   = 1'b1;
        w_seq_done_nxt     = 1'b0;
      end
      WAIT_LOCK: begin
        if (w_fault) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LOCK_TC) begin
          w_state_nxt        = REL_PERIPH;
          w_periph_reset_nxt = 1'b0;
          w_cnt_nxt          = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      REL_PERIPH, RUN: begin
        // Fault wins over the REL_PERIPH terminal count, so core reset can
        // never drop in the same cycle that lock or the button goes bad.
        if (w_fault) begin
          w_state_nxt        = WAIT_LOCK;
          w_cnt_nxt          = '0;
          w_periph_reset_nxt = 1'b1;
          w_core_reset_nxt   = 1'b1;
          w_seq_done_nxt     = 1'b0;
        end else if (r_state == REL_PERIPH) begin
          if (r_cnt == P2C_TC) begin
            w_state_nxt      = RUN;
            w_cnt_nxt        = '0;
            w_core_reset_nxt = 1'b0;
            w_seq_done_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = HOLD;
      end
    endcase
  end

  assign periph_reset = r_periph_reset;
  assign core_reset   = r_core_reset;
  assign seq_done     = r_seq_done;

`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
  logic [LOCK_LOSS_CNT_W-1:0] r_lock_loss_cnt;

  // Leaving REL_PERIPH/RUN on a lock drop takes one edge, so each drop is
  // counted exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_loss_cnt <= '0;
    end else if ((r_state == REL_PERIPH || r_state == RUN) && !w_lock_s &&
                 (r_lock_loss_cnt != {LOCK_LOSS_CNT_W{1'b1}})) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
    end
  end

  assign lock_loss_count = r_lock_loss_cnt;
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_soc_reset_sequencer
// Self-checking bench for soc_reset_sequencer. A behavioural model tracks the
// length of the current fault-free run and derives every expected output from
// it; directed scenarios are followed by a randomized soak.
// Honours RESET_SEQ_LOCK_LOSS_CNT_EN for the lock-loss counter expectations.
// -----------------------------------------------------------------------------
module tb_soc_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LOCK = 8;
  localparam int P2C  = 4;
  localparam int DEB  = 4;
  localparam int FULL = LOCK + P2C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       ext_reset_n = 1'b1;
  logic       periph_reset;
  logic       core_reset;
  logic       seq_done;
  logic [7:0] lock_loss_count;

  soc_reset_sequencer #(
    .SYNC_STAGES           (SYNC),
    .LOCK_STABLE_CYCLES    (LOCK),
    .PERIPH_TO_CORE_CYCLES (P2C),
    .DEBOUNCE_CYCLES       (DEB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_lock        (pll_lock),
    .ext_reset_n     (ext_reset_n),
    .periph_reset    (periph_reset),
    .core_reset      (core_reset),
    .seq_done        (seq_done),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: m_ok = consecutive fault-free cycles since the sequence last
  // restarted (saturating at FULL). periph released once m_ok >= LOCK,
  // core released once m_ok >= FULL.
  bit m_lock_q [SYNC];
  bit m_btn_q  [SYNC];
  bit m_deb;
  int m_deb_run;
  bit m_hold;
  int m_ok;
  int m_loss;

  function automatic int exp_loss();
`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  task automatic model_edge();
    bit lock_s;
    bit btn_s;
    bit fault;
    lock_s = m_lock_q[SYNC-1];
    btn_s  = m_btn_q[SYNC-1];
    fault  = !lock_s || !m_deb;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) begin
        m_lock_q[i] = 1'b0;
        m_btn_q[i]  = 1'b1;
      end
      m_deb = 1'b1; m_deb_run = 0; m_hold = 1'b1; m_ok = 0; m_loss = 0;
      return;
    end
    if (!m_hold && m_ok >= LOCK && !lock_s && m_loss < 255) m_loss++;
    if (m_hold) begin
      m_hold = 1'b0;
      m_ok   = 0;
    end else if (fault) begin
      m_ok = 0;
    end else if (m_ok < FULL) begin
      m_ok++;
    end
    if (btn_s != m_deb) begin
      m_deb_run++;
      if (m_deb_run == DEB) begin
        m_deb     = btn_s;
        m_deb_run = 0;
      end
    end else begin
      m_deb_run = 0;
    end
    for (int i = SYNC - 1; i > 0; i--) begin
      m_lock_q[i] = m_lock_q[i-1];
      m_btn_q[i]  = m_btn_q[i-1];
    end
    m_lock_q[0] = pll_lock;
    m_btn_q[0]  = ext_reset_n;
  endtask

  task automatic check_bit(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: advance the model at the edge, compare all outputs mid-cycle.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_bit("periph_reset", periph_reset, (m_ok < LOCK) ? 1'b1 : 1'b0);
    check_bit("core_reset", core_reset, (m_ok < FULL) ? 1'b1 : 1'b0);
    check_bit("seq_done", seq_done, (m_ok >= FULL) ? 1'b1 : 1'b0);
    check_val("lock_loss_count", {24'd0, lock_loss_count}, exp_loss());
    if (core_reset === 1'b0) check_bit("reset_order", periph_reset, 1'b0);
  endtask

  task automatic wait_done(string tag);
    int n;
    n = 0;
    while (seq_done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check_bit(tag, seq_done, 1'b1);
  endtask

  task automatic wait_ok(string tag, int target);
    int n;
    n = 0;
    while (m_ok != target && n < 200) begin
      step();
      n++;
    end
    total++;
    assert (n < 200) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=timeout expected=run_length_%0d", tag, cyc, target);
    end
  endtask

  initial begin
    int n;

    // Reset for 3 cycles: outputs at reset values.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();

    // Lock rises: periph falls SYNC+LOCK cycles later, core P2C after that.
    pll_lock = 1'b1;
    n = 0;
    while (periph_reset !== 1'b0 && n < 100) begin step(); n++; end
    check_val("lock_to_periph", n, SYNC + LOCK);
    n = 0;
    while (core_reset !== 1'b0 && n < 100) begin step(); n++; end
    check_val("periph_to_core", n, P2C);
    check_bit("run_done", seq_done, 1'b1);

    // One-cycle lock glitch after 5 stable WAIT_LOCK cycles restarts the count.
    reset = 1'b1; step(); reset = 1'b0;
    wait_ok("glitch_reach5", 5);
    pll_lock = 1'b0; step(); pll_lock = 1'b1;
    n = 0;
    while (periph_reset !== 1'b0 && n < 100) begin step(); n++; end
    check_val("glitch_restart", n, SYNC + LOCK);
    wait_done("glitch_run");

    // Lock drop in RUN: resets re-assert one cycle after lock_s falls.
    pll_lock = 1'b0;
    n = 0;
    while (periph_reset !== 1'b1 && n < 100) begin step(); n++; end
    check_val("run_drop_latency", n, SYNC + 1);
    check_bit("run_drop_core", core_reset, 1'b1);
    pll_lock = 1'b1;
    wait_done("drop_recover");

    // Short button pulse (3 cycles) is filtered.
    ext_reset_n = 1'b0; repeat (3) step(); ext_reset_n = 1'b1;
    repeat (10) step();
    check_bit("btn_short_ignored", seq_done, 1'b1);

    // Long press re-asserts, release replays debounce + full sequence.
    ext_reset_n = 1'b0; repeat (8) step();
    check_bit("btn_long_periph", periph_reset, 1'b1);
    ext_reset_n = 1'b1;
    n = 0;
    while (core_reset !== 1'b0 && n < 100) begin step(); n++; end
    check_val("btn_release_seq", n, SYNC + DEB + FULL);

    // lock_s drops exactly on REL_PERIPH terminal count: fault wins.
    reset = 1'b1; step(); reset = 1'b0;
    wait_ok("late_drop_reach", FULL - 1 - SYNC);
    pll_lock = 1'b0;
    repeat (4) step();
    check_bit("late_drop_core", core_reset, 1'b1);
    check_bit("late_drop_done", seq_done, 1'b0);
    pll_lock = 1'b1;
    wait_done("late_drop_recover");

    // Reset while in RUN returns everything to reset values on the next edge.
    pll_lock = 1'b0; repeat (4) step(); pll_lock = 1'b1;
    wait_done("pre_reset_run");
    reset = 1'b1; step();
    check_bit("reset_in_run_periph", periph_reset, 1'b1);
    check_val("reset_in_run_loss", {24'd0, lock_loss_count}, 32'd0);
    reset = 1'b0;

    // 300 lock drops: counter saturates.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      wait_done("drop_loop_run");
      pll_lock = 1'b0;
      repeat (3) step();
    end
    check_val("loss_saturate", {24'd0, lock_loss_count}, exp_loss());

    // Randomized soak against the model.
    pll_lock = 1'b1;
    repeat (4000) begin
      if ($urandom_range(15, 0) == 0) pll_lock = ~pll_lock;
      if ($urandom_range(11, 0) == 0) ext_reset_n = ~ext_reset_n;
      reset = ($urandom_range(399, 0) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
